// File: rtl/zmc2_fetch_seq.sv
// zmc2_fetch_seq: sequences one 16-pixel sprite line through the ZMC2 dot shifter.
// Ports: CLK_12M/RESET (async, active-high); START/X/HFLIP line request from the
// attribute pipeline; BUSY/DONE status; ROM_REQ/ROM_HALF/ROM_ACK/ROM_DATA C-ROM
// fetch handshake; CR/LOAD/H/EVEN shifter controls; LB_ADDR/LB_WE line-buffer pair write.
module zmc2_fetch_seq #(
  parameter int XW = 9
) (
  input  logic          CLK_12M,
  input  logic          RESET,
  input  logic          START,
  input  logic [XW-1:0] X,
  input  logic          HFLIP,
  output logic          BUSY,
  output logic          DONE,
  output logic          ROM_REQ,
  output logic          ROM_HALF,
  input  logic          ROM_ACK,
  input  logic [31:0]   ROM_DATA,
  output logic [31:0]   CR,
  output logic          LOAD,
  output logic          H,
  output logic          EVEN,
  output logic [XW-2:0] LB_ADDR,
  output logic          LB_WE
);
  typedef enum logic [2:0] {IDLE, FETCH_A, LOAD_A, SHIFT_A, LOAD_B, SHIFT_B, FIN} state_t;
  state_t r_state, w_next;
  logic [XW-2:0] r_base;
  logic [2:0] r_cnt;
  logic [31:0] r_cr, r_next;
  logic r_h, r_even, r_req, r_half, r_nv;
  logic w_ack, w_start, w_a_end, w_b_rdy;
  // an ACK without an outstanding request is ignored
  assign w_ack = ROM_ACK & r_req;
  assign w_start = (r_state == IDLE) & START;
  assign w_b_rdy = r_nv | w_ack;
  // r_cnt sits at 4 while SHIFT_A stalls waiting for the second word
  assign w_a_end = (r_state == SHIFT_A) & (r_cnt[2] | (r_cnt == 3'd3));
  assign CR = r_cr;
  assign H = r_h;
  assign EVEN = r_even;
  assign ROM_REQ = r_req;
  assign ROM_HALF = r_half;
  always_ff @(posedge CLK_12M or posedge RESET)
    if (RESET) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = START ? FETCH_A : IDLE;
      FETCH_A: w_next = w_ack ? LOAD_A : FETCH_A;
      LOAD_A:  w_next = SHIFT_A;
      SHIFT_A: w_next = (w_a_end & w_b_rdy) ? LOAD_B : SHIFT_A;
      LOAD_B:  w_next = SHIFT_B;
      SHIFT_B: w_next = (r_cnt == 3'd7) ? FIN : SHIFT_B;
      default: w_next = IDLE;
    endcase
    BUSY = r_state != IDLE;
    DONE = r_state == FIN;
    LOAD = (r_state == LOAD_A) | (r_state == LOAD_B);
    LB_WE = ((r_state == SHIFT_A) & ~r_cnt[2]) | (r_state == SHIFT_B);
    LB_ADDR = LB_WE ? r_base + {{(XW-4){1'b0}}, r_cnt} : '0;
  end
  always_ff @(posedge CLK_12M or posedge RESET) begin
    if (RESET) begin
      r_base <= '0;
      r_cnt <= '0;
      r_cr <= '0;
      r_next <= '0;
      r_h <= 1'b0;
      r_even <= 1'b0;
      r_req <= 1'b0;
      r_half <= 1'b0;
      r_nv <= 1'b0;
    end else begin
      if (w_start) begin
        r_base <= X[XW-1:1];
        r_even <= X[0];
        r_h <= HFLIP;
        r_req <= 1'b1;
        r_half <= HFLIP;
        r_nv <= 1'b0;
        r_cnt <= '0;
      end
      // the first ACK immediately reissues for the other half; the second ends fetching
      if (w_ack) begin
        r_req <= r_state == FETCH_A;
        r_half <= ~r_h;
      end
      if (w_ack & (r_state == FETCH_A)) r_cr <= ROM_DATA;
      if (w_ack & ((r_state == LOAD_A) | (r_state == SHIFT_A))) begin
        r_next <= ROM_DATA;
        r_nv <= 1'b1;
      end
      // a word arriving in the hand-over cycle bypasses NEXT straight into CR
      if (w_a_end & w_b_rdy) begin
        r_cr <= r_nv ? r_next : ROM_DATA;
        r_nv <= 1'b0;
      end
      if (LB_WE) r_cnt <= r_cnt + 3'd1;
      if (r_state == LOAD_A) r_cnt <= '0;
    end
  end
endmodule
